// File: rtl/buffer_tra_canakari.sv
// Transmit frame queue toward the CANakari controller: small FIFO of CAN frames,
// presented one at a time over tx_req/tx_ack with fixed back-off retry on error.

module buffer_tra_canakari_slot #(
  parameter int W = 79
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Storage is deliberately not reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (we) q <= d;
  end
endmodule

module buffer_tra_canakari #(
  parameter int DEPTH       = 4,
  parameter int MAX_RETRY   = 3,
  parameter int BACKOFF_CYC = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [10:0]                wr_id,
  input  logic [3:0]                 wr_dlc,
  input  logic [63:0]                wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       tx_req,
  output logic [10:0]                tx_id,
  output logic [3:0]                 tx_dlc,
  output logic [63:0]                tx_data,
  input  logic                       tx_ack,
  input  logic                       tx_err,
  output logic                       drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int BW = $clog2(BACKOFF_CYC + 1);

  typedef struct packed {
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
  } frame_t;
  localparam int FW = $bits(frame_t);

  typedef enum logic [1:0] {IDLE, SEND, BACKOFF} state_t;

  state_t                  state, state_nx;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           cnt;
  logic [RW-1:0]           retry, retry_nx;
  logic [BW-1:0]           bo_cnt, bo_nx;
  logic                    push, pop, load, req_nx, drop_nx;
  frame_t                  wr_frame, head;
  logic [DEPTH-1:0][FW-1:0] slot_q;
  logic [DEPTH-1:0]        slot_we;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign push     = wr_en && !full;
  assign wr_frame = '{id: wr_id, dlc: wr_dlc, data: wr_data};
  assign head     = frame_t'(slot_q[rd_ptr]);

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign slot_we[i] = push && (wr_ptr == AW'(i));
    buffer_tra_canakari_slot #(.W(FW)) u_slot (
      .clk (clk),
      .we  (slot_we[i]),
      .d   (wr_frame),
      .q   (slot_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state plus the pop/load/drop decisions; ack wins over err.
  always_comb begin
    state_nx = state;
    req_nx   = tx_req;
    retry_nx = retry;
    bo_nx    = bo_cnt;
    pop      = 1'b0;
    load     = 1'b0;
    drop_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          load     = 1'b1;
          req_nx   = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (tx_ack) begin
          pop      = 1'b1;
          retry_nx = '0;
          req_nx   = 1'b0;
          state_nx = IDLE;
        end else if (tx_err) begin
          req_nx = 1'b0;
          if (retry < RW'(MAX_RETRY)) begin
            retry_nx = retry + 1'b1;
            bo_nx    = BW'(BACKOFF_CYC - 1);
            state_nx = BACKOFF;
          end else begin
            pop      = 1'b1;
            drop_nx  = 1'b1;
            retry_nx = '0;
            state_nx = IDLE;
          end
        end
      end
      BACKOFF: begin
        if (bo_cnt == '0) begin
          req_nx   = 1'b1;
          state_nx = SEND;
        end else begin
          bo_nx = bo_cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      retry    <= '0;
      bo_cnt   <= '0;
      overflow <= 1'b0;
      drop     <= 1'b0;
      tx_req   <= 1'b0;
      tx_id    <= '0;
      tx_dlc   <= '0;
      tx_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt      <= cnt + CW'(push) - CW'(pop);
      retry    <= retry_nx;
      bo_cnt   <= bo_nx;
      overflow <= wr_en && full;
      drop     <= drop_nx;
      tx_req   <= req_nx;
      // Fields only change on a fresh load, so they hold through SEND and BACKOFF.
      if (load) begin
        tx_id   <= head.id;
        tx_dlc  <= head.dlc;
        tx_data <= head.data;
      end
    end
  end
endmodule

// File: tb/tb_buffer_tra_canakari.sv
// Randomized + directed bench for buffer_tra_canakari against a queue-based frame model.
module tb_buffer_tra_canakari;
  localparam int DEPTH = 4, MAX_RETRY = 3, BACKOFF_CYC = 16;

  typedef struct packed {
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
  } frm_t;

  logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0, tx_ack = 1'b0, tx_err = 1'b0;
  logic [10:0] wr_id = '0, tx_id;
  logic [3:0]  wr_dlc = '0, tx_dlc;
  logic [63:0] wr_data = '0, tx_data;
  logic        full, empty, overflow, tx_req, drop;
  logic [2:0]  count;

  buffer_tra_canakari #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .BACKOFF_CYC(BACKOFF_CYC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_id(wr_id), .wr_dlc(wr_dlc), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_req(tx_req), .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data(tx_data),
    .tx_ack(tx_ack), .tx_err(tx_err), .drop(drop)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_pass = 0;
  frm_t mq[$];
  frm_t m_cur;
  bit   m_req, m_ovf, m_drop, m_rstd;
  int   m_tries, m_wait;
  frm_t nil = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic frm_t rnd_frm();
    frm_t f;
    f.id   = 11'($urandom);
    f.dlc  = 4'($urandom);
    f.data = {$urandom, $urandom};
    return f;
  endfunction

  // Frame-level model: a queue of pending frames plus the transmit attempt status.
  task automatic model(input bit r, input bit w, input bit a, input bit e, input frm_t f);
    bit pop = 0;
    bit was_full;
    if (!r) begin
      mq.delete();
      m_req = 0; m_ovf = 0; m_drop = 0; m_tries = 0; m_wait = 0; m_rstd = 1;
      return;
    end
    was_full = (mq.size() == DEPTH);
    m_rstd = 0;
    m_drop = 0;
    m_ovf  = w && was_full;
    if (m_req) begin
      if (a) begin
        pop = 1; m_tries = 0; m_req = 0;
      end else if (e) begin
        m_req = 0;
        if (m_tries < MAX_RETRY) begin
          m_tries++; m_wait = BACKOFF_CYC;
        end else begin
          pop = 1; m_drop = 1; m_tries = 0;
        end
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_req = 1;
    end else if (mq.size() > 0) begin
      m_req = 1;
      m_cur = mq[0];
    end
    if (pop) void'(mq.pop_front());
    if (w && !was_full) mq.push_back(f);
  endtask

  task automatic step(input bit r, input bit w, input bit a, input bit e, input frm_t f);
    rst = r; wr_en = w; tx_ack = a; tx_err = e;
    {wr_id, wr_dlc, wr_data} = f;
    model(r, w, a, e, f);
    @(posedge clk);
    @(negedge clk);
    chk("count", count, mq.size());
    chk("full", full, mq.size() == DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("overflow", overflow, m_ovf);
    chk("drop", drop, m_drop);
    chk("tx_req", tx_req, m_req);
    if (m_req) begin
      chk("tx_id", tx_id, m_cur.id);
      chk("tx_dlc", tx_dlc, m_cur.dlc);
      chk("tx_data", tx_data, m_cur.data);
    end
    if (m_rstd) chk("rst_fields", {tx_id, tx_dlc, tx_data[48:0]}, 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 0, 0, 0, nil);
  endtask

  task automatic ack_when_req(input int n);
    repeat (n) step(1, 0, m_req, 0, nil);
  endtask

  initial begin
    frm_t f;
    bit r, w, a, e;
    @(negedge clk);
    step(0, 0, 0, 0, nil);
    step(0, 0, 0, 0, nil);

    // single frame, acked
    f.id = 11'h123; f.dlc = 4'd8; f.data = 64'h0807060504030201;
    step(1, 1, 0, 0, f);
    step(1, 0, 0, 0, nil);
    step(1, 0, 1, 0, nil);
    idle(2);

    // five writes into DEPTH=4, then drain in order across the wrap
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, rnd_frm());
    idle(3);
    repeat (12) step(1, 0, 1, 0, nil);

    // one error, back-off, then ack
    step(1, 1, 0, 0, rnd_frm());
    idle(1);
    step(1, 0, 0, 1, nil);
    idle(5);
    ack_when_req(20);

    // four errors on one frame -> drop, next frame presented
    step(1, 1, 0, 0, rnd_frm());
    step(1, 1, 0, 0, rnd_frm());
    repeat (62) step(1, 0, 0, m_req, nil);
    ack_when_req(10);

    // ack+err together at full with a write in the same cycle
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, rnd_frm());
    idle(2);
    step(1, 1, 1, 1, rnd_frm());
    ack_when_req(10);

    // reset during back-off with two frames queued
    step(1, 1, 0, 0, rnd_frm());
    step(1, 1, 0, 0, rnd_frm());
    idle(1);
    step(1, 0, 0, 1, nil);
    idle(3);
    step(0, 0, 0, 0, nil);
    step(1, 1, 0, 0, rnd_frm());
    step(1, 0, 0, 0, nil);
    ack_when_req(4);

    // randomized traffic
    repeat (3000) begin
      r = ($urandom_range(0, 299) != 0);
      w = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 4) == 0);
      e = ($urandom_range(0, 3) == 0);
      step(r, w, a, e, rnd_frm());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
